// File: rtl/mmc1_host_writer.sv
// mmc1_host_writer: CPU-side MMC1 serial write generator (5-write load or D7 reset write).
// Ports: CLK/nRES, req/cmd_reset/reg_sel/data in; busy/done, nROMSEL/CPU_RnW/A13/A14/D0/D7 out.
module mmc1_host_writer #(
  parameter int GAP = 1
) (
  input  logic       CLK,
  input  logic       nRES,
  input  logic       req,
  input  logic       cmd_reset,
  input  logic [1:0] reg_sel,
  input  logic [4:0] data,
  output logic       busy,
  output logic       done,
  output logic       nROMSEL,
  output logic       CPU_RnW,
  output logic       CPU_A13,
  output logic       CPU_A14,
  output logic       CPU_D0,
  output logic       CPU_D7
);

  // MMC1 drops writes on back-to-back M2 cycles, so at least one idle clock.
  generate
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
      $error("mmc1_host_writer: GAP must be 1..15");
    end
  endgenerate

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_GAPW,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_shift;
  logic [2:0] r_cnt;
  logic [3:0] r_gap;
  logic       r_rst;
  logic [1:0] r_sel;
  logic       w_accept;
  logic       w_gap_end;
  logic       w_last;

  // The edge leaving DONE is the first idle sample point, which gives
  // GAP+2 clocks from the last write to the next sequence's first write.
  assign w_accept  = req && (r_state == S_IDLE || r_state == S_DONE);
  assign w_gap_end = (r_gap == GAP_LAST);
  assign w_last    = r_rst || (r_cnt == 3'd4);

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    nROMSEL = 1'b1;
    CPU_RnW = 1'b1;
    CPU_A13 = 1'b0;
    CPU_A14 = 1'b0;
    CPU_D0  = 1'b0;
    CPU_D7  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_WR;
      end
      S_WR: begin
        busy    = 1'b1;
        nROMSEL = 1'b0;
        CPU_RnW = 1'b0;
        CPU_A13 = r_sel[0];
        CPU_A14 = r_sel[1];
        CPU_D0  = !r_rst && r_shift[0];
        CPU_D7  = r_rst;
        w_next  = S_GAPW;
      end
      S_GAPW: begin
        busy    = 1'b1;
        CPU_A13 = r_sel[0];
        CPU_A14 = r_sel[1];
        if (w_gap_end) w_next = w_last ? S_DONE : S_WR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = w_accept ? S_WR : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_rst   <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shift <= data;
        r_sel   <= reg_sel;
        r_rst   <= cmd_reset;
        r_cnt   <= '0;
        r_gap   <= '0;
      end else begin
        unique case (r_state)
          S_WR: r_gap <= '0;
          S_GAPW: begin
            if (w_gap_end) begin
              r_shift <= {1'b0, r_shift[4:1]};
              r_cnt   <= r_cnt + 3'd1;
            end else begin
              r_gap <= r_gap + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmc1_host_writer.sv
// tb_mmc1_host_writer: bench for mmc1_host_writer with an MMC1 receiver model.
// Instances: u0 (GAP=1) scoreboard-checked, u1 (GAP=3) checked cycle by cycle.
module tb_mmc1_host_writer;

  logic       CLK = 1'b1;
  logic       nRES = 1'b1;
  logic       req = 1'b0;
  logic       req3 = 1'b0;
  logic       cmd_reset = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [4:0] data = 5'd0;

  logic busy, done, nROMSEL, CPU_RnW, CPU_A13, CPU_A14, CPU_D0, CPU_D7;
  logic b3, dn3, nrs3, rnw3, a13_3, a14_3, d0_3, d7_3;

  mmc1_host_writer #(.GAP(1)) u0 (
    .CLK(CLK), .nRES(nRES), .req(req), .cmd_reset(cmd_reset),
    .reg_sel(reg_sel), .data(data), .busy(busy), .done(done),
    .nROMSEL(nROMSEL), .CPU_RnW(CPU_RnW), .CPU_A13(CPU_A13),
    .CPU_A14(CPU_A14), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7)
  );

  mmc1_host_writer #(.GAP(3)) u1 (
    .CLK(CLK), .nRES(nRES), .req(req3), .cmd_reset(cmd_reset),
    .reg_sel(reg_sel), .data(data), .busy(b3), .done(dn3),
    .nROMSEL(nrs3), .CPU_RnW(rnw3), .CPU_A13(a13_3),
    .CPU_A14(a14_3), .CPU_D0(d0_3), .CPU_D7(d7_3)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(negedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] rs;
    logic       d0;
    logic       d7;
  } wr_t;

  wr_t        wq[$];
  int         dq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] m_sh = '0;
  int         m_cnt = 0;
  logic [4:0] m_reg[4];
  logic       prev_wr = 1'b0;

  // Scoreboard consumer plus a small MMC1 serial-port model on u0's pins.
  initial begin
    wr_t e;
    int  dc;
    forever begin
      @(posedge CLK);
      if (!nRES) begin
        prev_wr = 1'b0;
      end else begin
        if (!nROMSEL) begin
          n_cmp++;
          if (wq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write cyc=%0d", cyc);
          end else begin
            e = wq.pop_front();
            if ({cyc, CPU_A14, CPU_A13, CPU_D0, CPU_D7, CPU_RnW, prev_wr}
                !== {e.c, e.rs, e.d0, e.d7, 1'b0, 1'b0}) begin
              n_err++;
              $display("FAIL write got cyc=%0d a=%b d0=%b d7=%b rnw=%b adj=%b exp cyc=%0d a=%b d0=%b d7=%b rnw=0 adj=0",
                       cyc, {CPU_A14, CPU_A13}, CPU_D0, CPU_D7, CPU_RnW, prev_wr,
                       e.c, e.rs, e.d0, e.d7);
            end
          end
          if (CPU_D7) begin
            m_sh  = '0;
            m_cnt = 0;
          end else begin
            m_sh = {CPU_D0, m_sh[4:1]};
            m_cnt++;
            if (m_cnt == 5) begin
              m_reg[{CPU_A14, CPU_A13}] = m_sh;
              m_sh  = '0;
              m_cnt = 0;
            end
          end
        end
        if (done) begin
          n_cmp++;
          if (dq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done cyc=%0d", cyc);
          end else begin
            dc = dq.pop_front();
            if (cyc !== dc) begin
              n_err++;
              $display("FAIL done_time got=%0d exp=%0d", cyc, dc);
            end
          end
        end
        prev_wr = !nROMSEL;
      end
    end
  end

  task automatic sync();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int e);
    int i;
    i = 0;
    do begin
      @(posedge CLK);
      i++;
    end while (cyc < e && i < 200);
    if (cyc != e) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, e);
    end
  endtask

  task automatic push_load(input int e0, input int gap,
                           input logic [1:0] rs, input logic [4:0] d);
    for (int k = 0; k < 5; k++)
      wq.push_back('{e0 + k * (1 + gap), rs, d[k], 1'b0});
    dq.push_back(e0 + 5 * (1 + gap));
  endtask

  task automatic check_drained(input string nm);
    n_cmp++;
    if (wq.size() != 0 || dq.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained got wq=%0d dq=%0d exp 0/0", nm, wq.size(), dq.size());
    end
    wq.delete();
    dq.delete();
  endtask

  task automatic check_reg(input string nm, input int r, input logic [4:0] exp);
    n_cmp++;
    if (m_reg[r] !== exp) begin
      n_err++;
      $display("FAIL %s_mmc1_reg%0d got=%b exp=%b", nm, r, m_reg[r], exp);
    end
  endtask

  task automatic run_load(input logic [1:0] rs, input logic [4:0] d);
    int e0;
    sync();
    req = 1'b1; cmd_reset = 1'b0; reg_sel = rs; data = d;
    e0 = cyc + 1;
    push_load(e0, 1, rs, d);
    sync();
    req = 1'b0;
    wait_cyc(e0 + 11);
    #1;
  endtask

  task automatic test_reset();
    #1 nRES = 1'b0;
    req = 1'b1; req3 = 1'b1; data = 5'h1f; reg_sel = 2'd3; cmd_reset = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      n_cmp++;
      if ({nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, busy, done,
           nrs3, rnw3, a14_3, a13_3, d0_3, d7_3, b3, dn3} !== 16'hC0C0) begin
        n_err++;
        $display("FAIL reset_idle got=%h exp=c0c0",
                 {nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, busy, done,
                  nrs3, rnw3, a14_3, a13_3, d0_3, d7_3, b3, dn3});
      end
    end
    sync();
    req = 1'b0; req3 = 1'b0;
    nRES = 1'b1;
  endtask

  task automatic test_load();
    int e0;
    sync();
    req = 1'b1; cmd_reset = 1'b0; reg_sel = 2'd2; data = 5'b10110;
    e0 = cyc + 1;
    push_load(e0, 1, 2'd2, 5'b10110);
    sync();
    req = 1'b0; data = 5'b00000;
    wait_cyc(e0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_busy_start got=%b exp=1", busy);
    end
    wait_cyc(e0 + 9);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL load_busy_e9 got=%b exp=10", {busy, done});
    end
    wait_cyc(e0 + 10);
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL load_busy_e10 got=%b exp=01", {busy, done});
    end
    wait_cyc(e0 + 11);
    #1;
    check_drained("load");
    check_reg("load", 2, 5'b10110);
  endtask

  task automatic test_abort();
    int e0;
    sync();
    req = 1'b1; cmd_reset = 1'b0; reg_sel = 2'd3; data = 5'b01011;
    e0 = cyc + 1;
    push_load(e0, 1, 2'd3, 5'b01011);
    sync();
    req = 1'b0;
    wait_cyc(e0 + 4);
    sync();
    nRES = 1'b0;
    #1;
    n_cmp++;
    if ({nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, busy, done} !== 8'hC0) begin
      n_err++;
      $display("FAIL abort_idle got=%h exp=c0",
               {nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, busy, done});
    end
    n_cmp++;
    if (wq.size() != 2 || dq.size() != 1 || m_cnt != 3) begin
      n_err++;
      $display("FAIL abort_left got wq=%0d dq=%0d bits=%0d exp 2/1/3",
               wq.size(), dq.size(), m_cnt);
    end
    wq.delete();
    dq.delete();
    sync();
    nRES = 1'b1;
    repeat (3) sync();
    run_load(2'd3, 5'b11010);
    check_drained("abort_restart");
  endtask

  task automatic test_cmd_reset();
    int e0;
    sync();
    req = 1'b1; cmd_reset = 1'b1; reg_sel = 2'd1; data = 5'b11111;
    e0 = cyc + 1;
    wq.push_back('{e0, 2'd1, 1'b0, 1'b1});
    dq.push_back(e0 + 2);
    sync();
    req = 1'b0; cmd_reset = 1'b0;
    wait_cyc(e0 + 3);
    #1;
    check_drained("cmd_reset");
    n_cmp++;
    if (m_cnt != 0 || m_sh !== 5'd0) begin
      n_err++;
      $display("FAIL cmd_reset_clear got bits=%0d sh=%b exp 0/00000", m_cnt, m_sh);
    end
    run_load(2'd1, 5'b00111);
    check_drained("after_reset");
    check_reg("after_reset", 1, 5'b00111);
  endtask

  task automatic test_back_to_back();
    int e0;
    sync();
    req = 1'b1; cmd_reset = 1'b0; reg_sel = 2'd0; data = 5'b10011;
    e0 = cyc + 1;
    push_load(e0, 1, 2'd0, 5'b10011);
    push_load(e0 + 11, 1, 2'd0, 5'b01101);
    while (cyc < e0 + 3) sync();
    data = 5'b01101;
    wait_cyc(e0 + 10);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy_done got=%b exp=0", busy);
    end
    wait_cyc(e0 + 11);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy_restart got=%b exp=1", busy);
    end
    sync();
    req = 1'b0;
    wait_cyc(e0 + 22);
    #1;
    check_drained("b2b");
    check_reg("b2b", 0, 5'b01101);
  endtask

  task automatic test_gap3();
    int         e0;
    logic [4:0] d;
    logic [4:0] got;
    logic       wr;
    logic [7:0] exp;
    d   = 5'b01100;
    got = '0;
    sync();
    req3 = 1'b1; cmd_reset = 1'b0; reg_sel = 2'd0; data = d;
    e0 = cyc + 1;
    sync();
    req3 = 1'b0; data = 5'b00000;
    for (int k = 0; k <= 20; k++) begin
      wait_cyc(e0 + k);
      wr  = (k % 4 == 0) && (k < 20);
      exp = {!wr, !wr, 2'b00, 1'b0, 1'b0, k < 20, k == 20};
      if (wr) begin
        exp[3] = d[k / 4];
        got[k / 4] = d0_3;
      end
      n_cmp++;
      if ({nrs3, rnw3, a14_3, a13_3, d0_3, d7_3, b3, dn3} !== exp) begin
        n_err++;
        $display("FAIL gap3_cycle k=%0d got=%b exp=%b", k,
                 {nrs3, rnw3, a14_3, a13_3, d0_3, d7_3, b3, dn3}, exp);
      end
    end
    n_cmp++;
    if (got !== d) begin
      n_err++;
      $display("FAIL gap3_bits got=%b exp=%b", got, d);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    test_reset();
    test_load();
    test_abort();
    test_cmd_reset();
    test_back_to_back();
    test_gap3();
    repeat (2) sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
